// File: rtl/mem_boot_loader.sv
// rtl/mem_boot_loader.sv - clears program memory, loads a framed image from a byte stream, verifies XOR checksum
module mem_boot_loader #(
  parameter int         ADDR_W    = 8,
  parameter int         MEM_BYTES = 256,
  parameter logic [7:0] FILL_EVEN = 8'h00,
  parameter logic [7:0] FILL_ODD  = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   bytes_loaded
);

  typedef enum logic [2:0] {
    S_FILL, S_WAIT_LEN, S_LOAD, S_CHECK, S_DONE, S_ERROR
  } state_t;

  typedef struct packed {
    logic rx_ready;
    logic busy;
    logic done;
    logic error;
    logic cpu_reset;
  } flags_t;

  localparam logic [ADDR_W:0] LAST_FILL = (ADDR_W+1)'(MEM_BYTES - 1);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

  state_t          state;
  flags_t          flags;
  logic [ADDR_W:0] fill_cnt;
  logic [ADDR_W:0] len;
  logic [7:0]      csum;
  logic            xfer;

  // Status outputs are registered alongside the state they describe.
  function automatic flags_t flags_of(input state_t s);
    flags_t f;
    f.rx_ready  = (s == S_WAIT_LEN) || (s == S_LOAD) || (s == S_CHECK);
    f.busy      = f.rx_ready || (s == S_FILL);
    f.done      = (s == S_DONE);
    f.error     = (s == S_ERROR);
    f.cpu_reset = (s != S_DONE);
    return f;
  endfunction

  assign rx_ready  = flags.rx_ready;
  assign busy      = flags.busy;
  assign done      = flags.done;
  assign error     = flags.error;
  assign cpu_reset = flags.cpu_reset;
  assign xfer      = rx_valid && flags.rx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_FILL;
      flags        <= flags_of(S_FILL);
      fill_cnt     <= '0;
      len          <= '0;
      csum         <= '0;
      bytes_loaded <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_FILL: begin
          mem_we    <= 1'b1;
          mem_addr  <= fill_cnt[ADDR_W-1:0];
          mem_wdata <= fill_cnt[0] ? FILL_ODD : FILL_EVEN;
          fill_cnt  <= fill_cnt + CNT_ONE;
          if (fill_cnt == LAST_FILL) begin
            state <= S_WAIT_LEN;
            flags <= flags_of(S_WAIT_LEN);
          end
        end
        S_WAIT_LEN: begin
          if (xfer) begin
            len          <= (ADDR_W+1)'(rx_data);
            csum         <= '0;
            bytes_loaded <= '0;
            if (int'(rx_data) > MEM_BYTES) begin
              state <= S_ERROR;
              flags <= flags_of(S_ERROR);
            end else if (rx_data == 8'h00) begin
              state <= S_CHECK;
              flags <= flags_of(S_CHECK);
            end else begin
              state <= S_LOAD;
              flags <= flags_of(S_LOAD);
            end
          end
        end
        S_LOAD: begin
          if (xfer) begin
            mem_we       <= 1'b1;
            mem_addr     <= bytes_loaded[ADDR_W-1:0];
            mem_wdata    <= rx_data;
            csum         <= csum ^ rx_data;
            bytes_loaded <= bytes_loaded + CNT_ONE;
            if ((bytes_loaded + CNT_ONE) == len) begin
              state <= S_CHECK;
              flags <= flags_of(S_CHECK);
            end
          end
        end
        S_CHECK: begin
          if (xfer) begin
            if (rx_data == csum) begin
              state <= S_DONE;
              flags <= flags_of(S_DONE);
            end else begin
              state <= S_ERROR;
              flags <= flags_of(S_ERROR);
            end
          end
        end
        S_DONE, S_ERROR: begin
          if (reload) begin
            state        <= S_FILL;
            flags        <= flags_of(S_FILL);
            fill_cnt     <= '0;
            len          <= '0;
            csum         <= '0;
            bytes_loaded <= '0;
          end
        end
        default: begin
          state    <= S_FILL;
          flags    <= flags_of(S_FILL);
          fill_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_boot_loader.sv
// tb/tb_mem_boot_loader.sv - self-checking bench for mem_boot_loader
module tb_mem_boot_loader;

  localparam logic [7:0] FE = 8'hE0;
  localparam logic [7:0] FO = 8'h0D;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       reload;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       error;
  logic [8:0] bytes_loaded;

  mem_boot_loader #(
    .ADDR_W(8), .MEM_BYTES(256), .FILL_EVEN(FE), .FILL_ODD(FO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .busy(busy), .done(done),
    .error(error), .bytes_loaded(bytes_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       rdy;
  } wr_t;
  wr_t wq[$];

  always @(negedge clk) if (mem_we) wq.push_back('{mem_addr, mem_wdata, rx_ready});

  typedef struct {
    int         len;
    logic [7:0] p[4];
    logic [7:0] cs;
    logic       exp_done;
  } vec_t;
  vec_t vt[6];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic await_fill(input string tag);
    int n = 0;
    int bad = 0;
    int rdy_bad = 0;
    while (!rx_ready && n < 600) begin @(negedge clk); n++; end
    chk({tag, "_fill_timeout"}, int'(n < 600), 1);
    @(negedge clk);
    chk({tag, "_fill_count"}, wq.size(), 256);
    foreach (wq[i]) begin
      if (wq[i].addr != 8'(i) || wq[i].data != ((i % 2 == 1) ? FO : FE)) bad++;
      if (i < 255 && wq[i].rdy) rdy_bad++;
    end
    chk({tag, "_fill_data"}, bad, 0);
    chk({tag, "_fill_rdy_low"}, rdy_bad, 0);
    chk({tag, "_fill_cpu_reset"}, int'(cpu_reset), 1);
    wq.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) chk("send_timeout", n, 0);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reload(input string tag);
    wq.delete();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk({tag, "_rl_done"}, int'(done), 0);
    chk({tag, "_rl_error"}, int'(error), 0);
    chk({tag, "_rl_cpu_reset"}, int'(cpu_reset), 1);
    chk({tag, "_rl_busy"}, int'(busy), 1);
    await_fill(tag);
  endtask

  // Drive one frame and compare against the expected outcome.
  task automatic run_frame(input string tag, input logic [7:0] pl[$], input logic [7:0] cs,
                           input logic exp_ok, input int max_gap);
    int bad = 0;
    wq.delete();
    send_byte(8'(pl.size()), $urandom_range(0, max_gap));
    foreach (pl[i]) send_byte(pl[i], $urandom_range(0, max_gap));
    chk({tag, "_pre_cs_cpu_reset"}, int'(cpu_reset), 1);
    send_byte(cs, $urandom_range(0, max_gap));
    chk({tag, "_done"}, int'(done), int'(exp_ok));
    chk({tag, "_error"}, int'(error), int'(!exp_ok));
    chk({tag, "_cpu_reset"}, int'(cpu_reset), int'(!exp_ok));
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_bytes_loaded"}, int'(bytes_loaded), pl.size());
    chk({tag, "_wr_count"}, wq.size(), pl.size());
    foreach (wq[i]) if (i < pl.size() && (wq[i].addr != 8'(i) || wq[i].data != pl[i])) bad++;
    chk({tag, "_wr_data"}, bad, 0);
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] x;
    logic [7:0] cs;

    vt[0] = '{3, '{8'hA1, 8'hB2, 8'hC3, 8'h00}, 8'hD0, 1'b1};
    vt[1] = '{2, '{8'h11, 8'h22, 8'h00, 8'h00}, 8'h00, 1'b0};
    vt[2] = '{0, '{8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 1'b1};
    vt[3] = '{0, '{8'h00, 8'h00, 8'h00, 8'h00}, 8'h5A, 1'b0};
    vt[4] = '{4, '{8'h01, 8'h02, 8'h04, 8'h08}, 8'h0F, 1'b1};
    vt[5] = '{1, '{8'hFF, 8'h00, 8'h00, 8'h00}, 8'hFF, 1'b1};

    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_rx_ready", int'(rx_ready), 0);
    chk("rst_cpu_reset", int'(cpu_reset), 1);
    chk("rst_busy", int'(busy), 1);
    chk("rst_done_error", int'({done, error}), 0);
    chk("rst_bytes_loaded", int'(bytes_loaded), 0);
    wq.delete();
    reset = 1'b1;
    await_fill("t1");

    for (int v = 0; v < 6; v++) begin
      pl.delete();
      for (int k = 0; k < vt[v].len; k++) pl.push_back(vt[v].p[k]);
      run_frame($sformatf("vec%0d", v), pl, vt[v].cs, vt[v].exp_done, 0);
      do_reload($sformatf("vec%0d", v));
    end

    // Valid gaps mid-payload, then a stream held valid while DONE.
    wq.delete();
    send_byte(8'h02, 0);
    send_byte(8'h05, 0);
    repeat (2) @(negedge clk);
    chk("gap_writes_so_far", wq.size(), 1);
    send_byte(8'h06, 0);
    send_byte(8'h03, 0);
    chk("gap_done", int'(done), 1);
    chk("gap_addr1", (wq.size() == 2) ? int'(wq[1].addr) : -1, 1);
    rx_data = 8'h77; rx_valid = 1'b1;
    repeat (5) @(negedge clk);
    rx_valid = 1'b0;
    chk("hold_no_write", wq.size(), 2);
    chk("hold_done", int'(done), 1);
    chk("hold_bytes", int'(bytes_loaded), 2);
    do_reload("gap");

    // Reload pulse during LOAD must be ignored.
    wq.delete();
    send_byte(8'h03, 0);
    send_byte(8'h10, 0);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("rl_ign_busy", int'(busy), 1);
    send_byte(8'h20, 0);
    send_byte(8'h30, 0);
    send_byte(8'h00, 0);
    chk("rl_ign_done", int'(done), 1);
    chk("rl_ign_writes", wq.size(), 3);
    do_reload("rlign");

    // Asynchronous reset after two of four payload bytes.
    send_byte(8'h04, 0);
    send_byte(8'h9C, 0);
    send_byte(8'h3E, 0);
    chk("mid_bytes", int'(bytes_loaded), 2);
    #2 reset = 1'b0;
    #1;
    chk("mid_mem_we", int'(mem_we), 0);
    chk("mid_mem_addr", int'(mem_addr), 0);
    chk("mid_mem_wdata", int'(mem_wdata), 0);
    chk("mid_rx_ready", int'(rx_ready), 0);
    chk("mid_cpu_reset", int'(cpu_reset), 1);
    chk("mid_busy", int'(busy), 1);
    chk("mid_bytes_rst", int'(bytes_loaded), 0);
    @(negedge clk);
    wq.delete();
    reset = 1'b1;
    await_fill("mid");

    // Random frames against a plain XOR reference.
    for (int f = 0; f < 8; f++) begin
      pl.delete();
      x = 8'h00;
      for (int k = 0, n = $urandom_range(0, 20); k < n; k++) begin
        pl.push_back(8'($urandom));
        x = x ^ pl[k];
      end
      cs = x;
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      run_frame($sformatf("rnd%0d", f), pl, cs, (cs == x), 2);
      do_reload($sformatf("rnd%0d", f));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
